run_sequencer: RTL

//  Parametrised run controller for core bring-up and regression, synthesizable in place of hand-timed reset stimulus.

---
 rtl/run_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Core bring-up run controller: reset-pulse train, bounded RUN window, retire/cycle counters.
// Optional commit-stall hang detection is enabled by defining RUN_SEQ_STALL_EN.
module run_sequencer #(
    parameter int unsigned NUM_PULSES    = 2,
    parameter int unsigned ASSERT_CYCLES = 3,
    parameter int unsigned GAP_CYCLES    = 3,
    parameter int unsigned RUN_CYCLES    = 50,
    parameter int unsigned COMMIT_WIDTH  = 2,
    parameter int unsigned STALL_LIMIT   = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    output logic                    core_reset,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        retired_count,
    output logic                    done,
    output logic                    timeout
);

    localparam int unsigned PHASE_MAX = (ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned PULSE_W   = $clog2(NUM_PULSES + 1);
    localparam int unsigned PC_W      = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned SUM_W     = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A RUN_CYCLES above the saturation point can never be reached, so done never fires.
    localparam bit RUN_FITS = (CNT_W >= 32) || (RUN_CYCLES < (32'd1 << CNT_W));
    localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(RUN_CYCLES);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHold = 3'd1,
        StGap  = 3'd2,
        StRun  = 3'd3,
        StDone = 3'd4,
        StHang = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 core_reset_q, core_reset_d;
    logic                 done_q, done_d;

    logic [PC_W-1:0]      commit_pop;
    logic [SUM_W-1:0]     retired_sum;
    logic [CNT_W-1:0]     cycle_inc, retired_inc;
    logic                 run_hit, hang_hit, restart;

    always_comb begin
        commit_pop = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_pop = commit_pop + PC_W'(commit_valid[i]);
        end
    end

    assign retired_sum = SUM_W'(retired_q) + SUM_W'(commit_pop);
    assign retired_inc = (retired_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : retired_sum[CNT_W-1:0];
    assign cycle_inc   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
    assign run_hit     = RUN_FITS && (cycle_inc == RUN_TARGET);
    assign restart     = start && ((state_q == StIdle) || (state_q == StDone) ||
                                   (state_q == StHang));

`ifdef RUN_SEQ_STALL_EN
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
    logic               timeout_q, timeout_d;
    logic               commit_any;

    assign commit_any = |commit_valid;
    assign stall_inc  = stall_q + STALL_W'(1);
    assign hang_hit   = (state_q == StRun) && !commit_any &&
                        (stall_inc == STALL_W'(STALL_LIMIT));

    always_comb begin
        stall_d   = stall_q;
        timeout_d = timeout_q;
        if (restart) begin
            stall_d   = '0;
            timeout_d = 1'b0;
        end else if (state_q == StRun) begin
            stall_d   = commit_any ? '0 : stall_inc;
            timeout_d = hang_hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign hang_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            pulse_q      <= '0;
            cycle_q      <= '0;
            retired_q    <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            pulse_q      <= pulse_d;
            cycle_q      <= cycle_d;
            retired_q    <= retired_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; hang takes priority over done in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StHang: begin
                if (start) state_d = StHold;
            end
            StHold: begin
                if (phase_q == PHASE_W'(1)) begin
                    state_d = (pulse_q < PULSE_W'(NUM_PULSES)) ? StGap : StRun;
                end
            end
            StGap: begin
                if (phase_q == PHASE_W'(1)) state_d = StHold;
            end
            StRun: begin
                if (hang_hit) begin
                    state_d = StHang;
                end else if (run_hit) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; core_reset is registered from the next state
    always_comb begin
        phase_d      = phase_q;
        pulse_d      = pulse_q;
        cycle_d      = cycle_q;
        retired_d    = retired_q;
        done_d       = done_q;
        core_reset_d = (state_d == StIdle) || (state_d == StHold);
        if (restart) begin
            phase_d   = PHASE_W'(ASSERT_CYCLES);
            pulse_d   = PULSE_W'(1);
            cycle_d   = '0;
            retired_d = '0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                StHold: begin
                    if (phase_q == PHASE_W'(1)) begin
                        phase_d = (state_d == StGap) ? PHASE_W'(GAP_CYCLES) : '0;
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
                StGap: begin
                    if (phase_q == PHASE_W'(1)) begin
                        phase_d = PHASE_W'(ASSERT_CYCLES);
                        pulse_d = pulse_q + PULSE_W'(1);
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
                StRun: begin
                    cycle_d   = cycle_inc;
                    retired_d = retired_inc;
                    done_d    = (state_d == StDone);
                end
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign core_reset    = core_reset_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
    assign done          = done_q;

endmodule
